// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-side controller of the asynchronous FIFO
module async_fifo_wr_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 2**ADDR_W - 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_req,
    input  logic [ADDR_W:0]   rptr_gray_async,
    input  logic              ovf_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    localparam int PW = ADDR_W + 1;
    localparam logic [ADDR_W:0] AFULL_V = PW'(AFULL_TH);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rq_gray;
    logic [ADDR_W:0] rq_bin;
    logic [ADDR_W:0] level_next;
    logic            full_next;
    logic [ADDR_W:0] sync_q [SYNC_STAGES];

    assign wr_en      = wr_req & ~full;
    assign waddr      = wbin[ADDR_W-1:0];
    assign rq_gray    = sync_q[SYNC_STAGES-1];
    assign wbin_next  = wbin + PW'(wr_en);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rq_bin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rq_bin[i] = ^(rq_gray >> i);
        end
    end

    assign level_next = wbin_next - rq_bin;
    assign full_next  = (wgray_next == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]});

    // Plain flop chain; nothing may sit between stages of a CDC synchronizer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= full_next;
            almost_full <= (level_next >= AFULL_V);
            wr_level    <= level_next;
            if (wr_req && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - self-checking bench for async_fifo_wr_ctrl (depth 8)
module tb_async_fifo_wr_ctrl;

    logic       clk;
    logic       nrst;
    logic       wr_req;
    logic [3:0] rptr_gray_async;
    logic       ovf_clr;
    logic       wr_en;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int rcnt;
    int checks;
    int failures;

    int m_w, m_level, s0, s1, acc;
    bit m_full, m_af, m_ovf;
    logic [3:0] prev_g;
    int gseq[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};

    async_fifo_wr_ctrl #(
        .ADDR_W(3),
        .SYNC_STAGES(2),
        .AFULL_TH(6)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .wr_req(wr_req),
        .rptr_gray_async(rptr_gray_async),
        .ovf_clr(ovf_clr),
        .wr_en(wr_en),
        .waddr(waddr),
        .wptr_gray(wptr_gray),
        .full(full),
        .almost_full(almost_full),
        .wr_level(wr_level),
        .overflow(overflow)
    );

    assign rptr_gray_async = 4'(rcnt) ^ (4'(rcnt) >> 1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Occupancy model: counts of writes and reads; the read count reaches the
    // flags two edges after it is sampled.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_w = 0; m_level = 0; s0 = 0; s1 = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            acc = (wr_req && !m_full) ? 1 : 0;
            if (wr_req && m_full) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_w     = (m_w + acc) % 16;
            m_level = (m_w - s1 + 16) % 16;
            m_full  = (m_level == 8);
            m_af    = (m_level >= 6);
            s1 = s0;
            s0 = rcnt % 16;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("m_wr_en", int'(wr_en), int'(wr_req && !m_full));
        chk("m_waddr", int'(waddr), m_w % 8);
        chk("m_wptr_gray", int'(wptr_gray), m_w ^ (m_w >> 1));
        chk("m_full", int'(full), int'(m_full));
        chk("m_almost_full", int'(almost_full), int'(m_af));
        chk("m_wr_level", int'(wr_level), m_level);
        chk("m_overflow", int'(overflow), int'(m_ovf));
        if (!nrst) begin
            prev_g = '0;
        end else if (wptr_gray != prev_g) begin
            chk("gray_one_bit", $countones(wptr_gray ^ prev_g), 1);
            prev_g = wptr_gray;
        end
    end

    initial begin
        nrst = 1'b0; wr_req = 1'b0; ovf_clr = 1'b0; rcnt = 0;
        checks = 0; failures = 0; prev_g = '0;

        // reset state, wr_en combinational
        tick(); tick();
        wr_req = 1'b1;
        #1;
        chk("rst_wr_en", int'(wr_en), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_level", int'(wr_level), 0);
        chk("rst_gray", int'(wptr_gray), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_waddr", int'(waddr), 0);
        wr_req = 1'b0;
        tick();
        nrst = 1'b1;

        // eight writes to full
        wr_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_waddr", int'(waddr), i);
            tick();
            chk("fill_gray", int'(wptr_gray), gseq[i+1]);
            if (i == 4) chk("af_before", int'(almost_full), 0);
            if (i == 5) chk("af_at6", int'(almost_full), 1);
            if (i == 6) chk("full_before", int'(full), 0);
        end
        chk("full_at8", int'(full), 1);
        chk("level_at8", int'(wr_level), 8);

        // overflow while full
        repeat (3) begin
            tick();
            chk("ovf_wr_en", int'(wr_en), 0);
            chk("ovf_waddr", int'(waddr), 0);
            chk("ovf_gray", int'(wptr_gray), 12);
            chk("ovf_set", int'(overflow), 1);
        end
        ovf_clr = 1'b1;
        tick();
        chk("ovf_set_wins", int'(overflow), 1);
        wr_req = 1'b0;
        tick();
        chk("ovf_cleared", int'(overflow), 0);
        ovf_clr = 1'b0;

        // release latency
        rcnt = 1;
        tick(); tick();
        chk("full_edge2", int'(full), 1);
        tick();
        chk("full_edge3", int'(full), 0);
        chk("level_edge3", int'(wr_level), 7);
        wr_req = 1'b1;
        #1;
        chk("rel_wr_en", int'(wr_en), 1);
        tick();
        chk("refull", int'(full), 1);
        chk("refull_level", int'(wr_level), 8);
        chk("refull_waddr", int'(waddr), 1);
        wr_req = 1'b0;

        // streaming across the pointer wrap
        for (int j = 0; j < 20; j++) begin
            rcnt = rcnt + 1;
            wr_req = 1'b1;
            tick();
        end
        wr_req = 1'b0;
        repeat (4) tick();
        chk("wrap_level", int'(wr_level), 5);
        chk("wrap_waddr", int'(waddr), 2);
        chk("wrap_gray", int'(wptr_gray), 15);
        chk("wrap_full", int'(full), 0);

        // asynchronous reset mid-burst
        nrst = 1'b0; rcnt = 0;
        tick();
        nrst = 1'b1;
        tick(); tick();
        wr_req = 1'b1;
        repeat (5) tick();
        chk("burst_level", int'(wr_level), 5);
        chk("burst_waddr", int'(waddr), 5);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_level", int'(wr_level), 0);
        chk("arst_waddr", int'(waddr), 0);
        chk("arst_gray", int'(wptr_gray), 0);
        chk("arst_wr_en", int'(wr_en), 1);
        @(posedge clk);
        #3;
        nrst = 1'b1;
        chk("resume_waddr0", int'(waddr), 0);
        tick();
        chk("resume_waddr1", int'(waddr), 1);
        chk("resume_gray", int'(wptr_gray), 1);
        wr_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
